// File: rtl/se_array_loader_if.sv
// Valid/ready element stream that feeds se_array_loader.
// The master is the element source and the slave is the loader.
interface se_array_loader_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/se_array_loader.sv
// Packs a valid/ready element stream into the even-odd sorter's flattened array bus and launches it.
// Optional feature macro SE_LOADER_PAD_SHORT_EN: in_last closes a short frame, padding the tail with PAD_VALUE.
module se_array_loader #(
  parameter int                   ARRAYLENGTH = 10,
  parameter int                   DATAWIDTH   = 8,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  se_array_loader_if.slave                     s_in,
  output logic [0:ARRAYLENGTH*DATAWIDTH-1]     array_out,
  output logic                                 valid_out,
  input  logic                                 sort_done,
  output logic                                 busy,
  output logic [$clog2(ARRAYLENGTH+1)-1:0]     fill_count,
  output logic                                 short_err
);

  localparam int unsigned CW = $clog2(ARRAYLENGTH + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(ARRAYLENGTH - 1);

  if (ARRAYLENGTH < 2 || $bits(PAD_VALUE) != DATAWIDTH) begin : g_param_check
    $error("se_array_loader: ARRAYLENGTH must be >= 2 and PAD_VALUE DATAWIDTH bits wide");
  end

  typedef enum logic [1:0] {
    S_FILL,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [CW-1:0]                    r_fill;
  logic [0:ARRAYLENGTH*DATAWIDTH-1] r_array;
  logic                             r_short_err;
  logic                             w_xfer;
  logic                             w_last_slot;
  logic                             w_close;

  always_comb begin
    w_xfer      = s_in.in_valid && s_in.in_ready;
    w_last_slot = (r_fill == LAST_SLOT);
`ifdef SE_LOADER_PAD_SHORT_EN
    w_close     = w_xfer && (w_last_slot || s_in.in_last);
`else
    w_close     = w_xfer && w_last_slot;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL:   if (w_close) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (sort_done) w_next = S_FILL;
      default:  w_next = S_FILL;
    endcase
  end

  always_comb begin
    s_in.in_ready = (r_state == S_FILL) && !rst;
    valid_out     = (r_state == S_LAUNCH);
    busy          = (r_state != S_FILL);
    array_out     = r_array;
    fill_count    = r_fill;
    short_err     = r_short_err;
  end

  // Slot k sits at bits [k*DATAWIDTH +: DATAWIDTH]; with the ascending range slot 0 is the MSB end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill      <= '0;
      r_array     <= '0;
      r_short_err <= 1'b0;
    end else begin
`ifdef SE_LOADER_PAD_SHORT_EN
      r_short_err <= 1'b0;
`else
      r_short_err <= w_xfer && s_in.in_last && !w_last_slot;
`endif
      if (w_xfer) begin
        for (int unsigned j = 0; j < ARRAYLENGTH; j++) begin
          if (CW'(j) == r_fill) begin
            r_array[j*DATAWIDTH +: DATAWIDTH] <= s_in.in_data;
          end
`ifdef SE_LOADER_PAD_SHORT_EN
          else if (s_in.in_last && (CW'(j) > r_fill)) begin
            r_array[j*DATAWIDTH +: DATAWIDTH] <= PAD_VALUE;
          end
`endif
        end
        r_fill <= w_close ? '0 : r_fill + 1'b1;
      end
    end
  end

endmodule
